// File: rtl/noc_credit_sink.sv
// Credit-flow flit sink: FIFO buffer, credit return, packet framing checks.
// Define NOC_CREDIT_SINK_STATS_EN to build the flit/packet statistics counters.
module noc_credit_sink #(
  parameter int FLIT_WIDTH        = 32,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 2,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] out_data,
  output logic [DEST_WIDTH-1:0] out_dest,
  output logic                  out_tail,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow_err,
  output logic                  framing_err,
  output logic                  in_packet,
  output logic [CNT_WIDTH-1:0]  flit_count,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  // state   | meaning
  // IDLE    | no packet open; next popped non-tail flit opens one
  // OPEN    | head popped, tail not yet popped; dest must stay constant
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OPEN = 1'b1;

  localparam int PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int OCC_W = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(FLIT_BUFFER_DEPTH);

  logic [FLIT_WIDTH-1:0] r_data_mem [FLIT_BUFFER_DEPTH];
  logic [DEST_WIDTH-1:0] r_dest_mem [FLIT_BUFFER_DEPTH];
  logic                  r_tail_mem [FLIT_BUFFER_DEPTH];

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_count;
  logic                  r_credit;
  logic                  r_overflow;
  logic                  r_framing;
  logic [0:0]            r_state;
  logic [DEST_WIDTH-1:0] r_pkt_dest;

  logic w_valid;
  logic w_pop;
  logic w_push;
  logic w_overflow;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign w_valid    = (r_count != '0);
  assign w_pop      = w_valid && out_ready;
  assign w_push     = send_in && ((r_count != FULL_CNT) || w_pop);
  assign w_overflow = send_in && !w_push;

  always_ff @(posedge clk_noc) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= data_in;
      r_dest_mem[r_wr_ptr] <= dest_in;
      r_tail_mem[r_wr_ptr] <= is_tail_in;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_credit   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_credit <= w_pop;
      if (w_overflow) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_framing  <= 1'b0;
      r_pkt_dest <= '0;
    end else if (w_pop) begin
      case (r_state)
        ST_IDLE: begin
          if (!out_tail) begin
            r_state    <= ST_OPEN;
            r_pkt_dest <= out_dest;
          end
        end
        default: begin
          if (out_dest != r_pkt_dest) r_framing <= 1'b1;
          if (out_tail) r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef NOC_CREDIT_SINK_STATS_EN
  logic [CNT_WIDTH-1:0] r_flit_cnt;
  logic [CNT_WIDTH-1:0] r_pkt_cnt;

  always_ff @(posedge clk_noc) begin
    if (!rst_n) begin
      r_flit_cnt <= '0;
      r_pkt_cnt  <= '0;
    end else if (w_pop) begin
      r_flit_cnt <= r_flit_cnt + 1'b1;
      if (out_tail) r_pkt_cnt <= r_pkt_cnt + 1'b1;
    end
  end

  assign flit_count = r_flit_cnt;
  assign pkt_count  = r_pkt_cnt;
`else
  assign flit_count = '0;
  assign pkt_count  = '0;
`endif

  // Tail storage is not reset, so gate it to keep out_tail low while empty.
  assign out_data     = r_data_mem[r_rd_ptr];
  assign out_dest     = r_dest_mem[r_rd_ptr];
  assign out_tail     = w_valid && r_tail_mem[r_rd_ptr];
  assign out_valid    = w_valid;
  assign credit_out   = r_credit;
  assign overflow_err = r_overflow;
  assign framing_err  = r_framing;
  assign in_packet    = (r_state == ST_OPEN);

endmodule

// File: tb/tb_noc_credit_sink.sv
// Directed self-checking bench for noc_credit_sink (DEPTH=2); counter
// expectations follow whether NOC_CREDIT_SINK_STATS_EN is defined.
module tb_noc_credit_sink;

  logic        clk_noc = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic [5:0]  dest_in;
  logic        is_tail_in;
  logic        send_in;
  logic        credit_out;
  logic [31:0] out_data;
  logic [5:0]  out_dest;
  logic        out_tail;
  logic        out_valid;
  logic        out_ready;
  logic        overflow_err;
  logic        framing_err;
  logic        in_packet;
  logic [15:0] flit_count;
  logic [15:0] pkt_count;

`ifdef NOC_CREDIT_SINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk_noc = ~clk_noc;

  noc_credit_sink #(
    .FLIT_WIDTH(32), .DEST_WIDTH(6), .FLIT_BUFFER_DEPTH(2), .CNT_WIDTH(16)
  ) dut (
    .clk_noc(clk_noc), .rst_n(rst_n),
    .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
    .credit_out(credit_out),
    .out_data(out_data), .out_dest(out_dest), .out_tail(out_tail),
    .out_valid(out_valid), .out_ready(out_ready),
    .overflow_err(overflow_err), .framing_err(framing_err), .in_packet(in_packet),
    .flit_count(flit_count), .pkt_count(pkt_count)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_pops = 0;
  int n_credits = 0;
  logic [31:0] popped_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] cnt_exp(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  // Record the pop that the coming edge will perform, then sample after it.
  task automatic step();
    if (rst_n && out_valid && out_ready) begin
      n_pops++;
      popped_q.push_back(out_data);
    end
    @(posedge clk_noc);
    #1;
    if (credit_out) n_credits++;
  endtask

  task automatic drive(input logic [31:0] d, input logic [5:0] dst, input logic tl);
    send_in    = 1'b1;
    data_in    = d;
    dest_in    = dst;
    is_tail_in = tl;
  endtask

  task automatic idle();
    send_in    = 1'b0;
    data_in    = '0;
    dest_in    = '0;
    is_tail_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    idle();
    step();
    step();
    rst_n = 1'b1;
    popped_q.delete();
    n_pops    = 0;
    n_credits = 0;
  endtask

  int credits;
  int sent;
  int cycles;

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle();

    // Reset values, then a 3-flit packet streamed with out_ready=1.
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_credit", credit_out, 0);
    check("rst_out_tail", out_tail, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_framing", framing_err, 0);
    check("rst_in_packet", in_packet, 0);
    check("rst_flit_count", flit_count, 0);
    check("rst_pkt_count", pkt_count, 0);

    out_ready = 1'b1;
    drive(32'hA0, 6'h12, 1'b0); step();
    check("p1_valid_f0", out_valid, 1);
    check("p1_data_f0", out_data, 32'hA0);
    check("p1_credit_none", credit_out, 0);
    drive(32'hA1, 6'h12, 1'b0); step();
    check("p1_credit_f0", credit_out, 1);
    check("p1_in_packet", in_packet, 1);
    check("p1_data_f1", out_data, 32'hA1);
    drive(32'hA2, 6'h12, 1'b1); step();
    check("p1_credit_f1", credit_out, 1);
    check("p1_data_f2", out_data, 32'hA2);
    check("p1_tail_f2", out_tail, 1);
    idle(); step();
    check("p1_credit_f2", credit_out, 1);
    check("p1_valid_empty", out_valid, 0);
    check("p1_in_packet_closed", in_packet, 0);
    step();
    check("p1_credit_off", credit_out, 0);
    check("p1_credit_total", n_credits, 3);
    check("p1_flit_count", flit_count, cnt_exp(3));
    check("p1_pkt_count", pkt_count, cnt_exp(1));
    check("p1_framing", framing_err, 0);

    // Fill to DEPTH with consumer stalled, third flit must overflow.
    do_reset();
    drive(32'hB0, 6'h01, 1'b0); step();
    drive(32'hB1, 6'h01, 1'b1); step();
    check("ovf_head", out_data, 32'hB0);
    check("ovf_not_yet", overflow_err, 0);
    drive(32'hB2, 6'h01, 1'b1); step();
    check("ovf_set", overflow_err, 1);
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("ovf_pops", n_pops, 2);
    check("ovf_credits", n_credits, 2);
    if (popped_q.size() == 2) begin
      check("ovf_order0", popped_q[0], 32'hB0);
      check("ovf_order1", popped_q[1], 32'hB1);
    end
    check("ovf_empty", out_valid, 0);
    check("ovf_sticky", overflow_err, 1);

    // Full FIFO with push and pop in the same cycle.
    do_reset();
    drive(32'hC0, 6'h03, 1'b0); step();
    drive(32'hC1, 6'h03, 1'b0); step();
    drive(32'hC2, 6'h03, 1'b1);
    out_ready = 1'b1;
    step();
    check("full_pp_no_ovf", overflow_err, 0);
    check("full_pp_head", out_data, 32'hC1);
    check("full_pp_credit", credit_out, 1);
    idle(); step();
    check("full_pp_head2", out_data, 32'hC2);
    step();
    check("full_pp_empty", out_valid, 0);
    check("full_pp_pops", n_pops, 3);
    if (popped_q.size() == 3) begin
      check("full_pp_order0", popped_q[0], 32'hC0);
      check("full_pp_order1", popped_q[1], 32'hC1);
      check("full_pp_order2", popped_q[2], 32'hC2);
    end

    // Dest change mid-packet.
    do_reset();
    out_ready = 1'b1;
    drive(32'hD0, 6'h05, 1'b0); step();
    drive(32'hD1, 6'h05, 1'b0); step();
    check("frm_in_packet", in_packet, 1);
    drive(32'hD2, 6'h07, 1'b1); step();
    check("frm_clean_so_far", framing_err, 0);
    check("frm_head_dest", out_dest, 6'h07);
    idle(); step();
    check("frm_set", framing_err, 1);
    check("frm_in_packet_closed", in_packet, 0);
    check("frm_pops", n_pops, 3);

    // 100 back-to-back flits with a modelled upstream credit loop.
    do_reset();
    out_ready = 1'b1;
    credits = 2;
    sent = 0;
    cycles = 0;
    while (sent < 100 && cycles < 200) begin
      if (credits > 0) begin
        drive(32'hE000 + 32'(sent), 6'h01, (sent % 4) == 3);
        credits--;
        sent++;
      end else begin
        idle();
      end
      step();
      cycles++;
      if (credit_out) credits++;
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      step();
      if (credit_out) credits++;
    end
    check("tp_cycles", cycles, 100);
    check("tp_sent", sent, 100);
    check("tp_no_ovf", overflow_err, 0);
    check("tp_pops", n_pops, 100);
    check("tp_credits_back", credits, 2);
    check("tp_flit_count", flit_count, cnt_exp(100));
    check("tp_pkt_count", pkt_count, cnt_exp(25));
    check("tp_framing", framing_err, 0);

    // Reset with two flits buffered and a credit pending.
    do_reset();
    drive(32'hF0, 6'h02, 1'b0); step();
    drive(32'hF1, 6'h02, 1'b0); step();
    drive(32'hF2, 6'h02, 1'b1);
    out_ready = 1'b1;
    step();
    check("mid_pre_credit", credit_out, 1);
    check("mid_pre_in_packet", in_packet, 1);
    check("mid_pre_valid", out_valid, 1);
    check("mid_pre_flit_count", flit_count, cnt_exp(1));
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle();
    step();
    check("mid_valid", out_valid, 0);
    check("mid_credit", credit_out, 0);
    check("mid_in_packet", in_packet, 0);
    check("mid_flit_count", flit_count, 0);
    check("mid_pkt_count", pkt_count, 0);
    rst_n = 1'b1;
    step();
    check("mid_discarded", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
